// File: rtl/nand_pkg.sv
// nand_pkg: shared constants for the NAND page-read setup stage
// (command bytes, CPINS bit positions, idle pin levels, FSM state encoding,
// address byte selection).
package nand_pkg;

  localparam logic [7:0] CMD_READ_1ST = 8'h00;
  localparam logic [7:0] CMD_READ_2ND = 8'h30;

  localparam int CP_WE  = 0;
  localparam int CP_CE  = 1;
  localparam int CP_CLE = 2;
  localparam int CP_ALE = 3;
  localparam int CP_RE  = 4;

  // WE#=1, CE#=1, CLE=0, ALE=0, RE#=1
  localparam logic [4:0] CPINS_IDLE = 5'b10011;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CMD1    = 3'd1;
  localparam logic [2:0] S_ADDR    = 3'd2;
  localparam logic [2:0] S_CMD2    = 3'd3;
  localparam logic [2:0] S_TWB     = 3'd4;
  localparam logic [2:0] S_WAIT_RB = 3'd5;
  localparam logic [2:0] S_HANDOFF = 3'd6;

  // Address bytes go out LSB-first: col low, col high, row low, row mid, row high.
  function automatic logic [7:0] addr_byte(input logic [15:0] col,
                                           input logic [23:0] row,
                                           input int          idx);
    logic [7:0] b;
    case (idx)
      0:       b = col[7:0];
      1:       b = col[15:8];
      2:       b = row[7:0];
      3:       b = row[15:8];
      default: b = row[23:16];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/nand_read_setup_if.sv
// nand_read_setup_if: request/handoff and NAND pin bundle of the read setup stage.
// slave = the setup stage itself, master = whatever drives requests and the NAND pins model.
interface nand_read_setup_if;
  logic        start;
  logic [15:0] col_addr;
  logic [23:0] row_addr;
  logic        rb_n;
  logic        read_complete;
  logic [4:0]  CPINS;
  logic [7:0]  io_out;
  logic        io_oe;
  logic        read_start;
  logic        busy;
  logic        timeout_err;

  modport master (
    output start, col_addr, row_addr, rb_n, read_complete,
    input  CPINS, io_out, io_oe, read_start, busy, timeout_err
  );

  modport slave (
    input  start, col_addr, row_addr, rb_n, read_complete,
    output CPINS, io_out, io_oe, read_start, busy, timeout_err
  );
endinterface

// File: rtl/nand_read_setup_bus_cycle.sv
// nand_bus_cycle: one NAND command/address write cycle. A go pulse latches the
// byte and its type; WE# is low for WE_LOW_CYCLES then high for WE_HIGH_CYCLES
// with IO/CLE/ALE held. done is high in the last high clock so the next go can
// start the following cycle with no idle gap.
module nand_bus_cycle
  import nand_pkg::*;
#(
  parameter int WE_LOW_CYCLES  = 1,
  parameter int WE_HIGH_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [7:0] byte_in,
  input  logic       is_cmd,
  output logic       we_n,
  output logic       cle,
  output logic       ale,
  output logic       io_oe,
  output logic [7:0] io_out,
  output logic       active,
  output logic       done
);

  localparam int PH_MAX = (WE_LOW_CYCLES > WE_HIGH_CYCLES) ? WE_LOW_CYCLES : WE_HIGH_CYCLES;
  localparam int CW     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  logic          active_q, active_d;
  logic          high_q, high_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    byte_q, byte_d;
  logic          cmd_q, cmd_d;
  logic          accept;

  // Phase sequencing: accept a new byte when idle or finishing, else walk low then high phase.
  always_comb begin
    active_d = active_q;
    high_d   = high_q;
    cnt_d    = cnt_q;
    byte_d   = byte_q;
    cmd_d    = cmd_q;
    done     = active_q && high_q && (cnt_q == CW'(WE_HIGH_CYCLES - 1));
    accept   = go && (!active_q || done);
    if (accept) begin
      active_d = 1'b1;
      high_d   = 1'b0;
      cnt_d    = '0;
      byte_d   = byte_in;
      cmd_d    = is_cmd;
    end else if (done) begin
      active_d = 1'b0;
      high_d   = 1'b0;
      cnt_d    = '0;
    end else if (active_q) begin
      if (!high_q && (cnt_q == CW'(WE_LOW_CYCLES - 1))) begin
        high_d = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Control state, cleared by reset so the pins fall back to idle immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      high_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      active_q <= active_d;
      high_q   <= high_d;
      cnt_q    <= cnt_d;
    end
  end

  // Latched byte and cycle type; only observed while active.
  always_ff @(posedge clk) begin
    byte_q <= byte_d;
    cmd_q  <= cmd_d;
  end

  assign active = active_q;
  assign we_n   = !(active_q && !high_q);
  assign cle    = active_q && cmd_q;
  assign ale    = active_q && !cmd_q;
  assign io_oe  = active_q;
  assign io_out = active_q ? byte_q : 8'h00;

endmodule

// File: rtl/nand_read_setup.sv
// nand_read_setup: command/address phase of a NAND page read. Sends 00h, the
// address bytes and 30h, waits tWB and the R/B# busy period, then raises
// read_start and keeps CE# low until the data-read stage reports completion.
// Optional: define NAND_RB_TIMEOUT_EN to bound the R/B# wait with TIMEOUT_CYCLES
// and report expiry on the sticky timeout_err output.
module nand_read_setup
  import nand_pkg::*;
#(
  parameter int ADDR_CYCLES    = 5,
  parameter int WE_LOW_CYCLES  = 1,
  parameter int WE_HIGH_CYCLES = 1,
  parameter int TWB_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic             clk,
  input  logic             rst,
  nand_read_setup_if.slave bus
);

  if (ADDR_CYCLES < 4 || ADDR_CYCLES > 5 || WE_LOW_CYCLES < 1 || WE_HIGH_CYCLES < 1 ||
      TWB_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("nand_read_setup: ADDR_CYCLES must be 4 or 5 and timing parameters >= 1");
  end

  localparam int IW = $clog2(ADDR_CYCLES + 1);
  localparam int TW = (TWB_CYCLES > 1) ? $clog2(TWB_CYCLES) : 1;

  logic [2:0]    state_q, state_d;
  logic [15:0]   col_q, col_d;
  logic [23:0]   row_q, row_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [TW-1:0] twb_cnt_q, twb_cnt_d;
  logic          rb_meta_q, rb_sync_q;

`ifdef NAND_RB_TIMEOUT_EN
  localparam int OW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [OW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          timeout_err_q, timeout_err_d;
`endif

  logic       go;
  logic [7:0] go_byte;
  logic       go_cmd;
  logic       bc_we_n, bc_cle, bc_ale, bc_oe, bc_active, bc_done;
  logic [7:0] bc_io;
  logic [4:0] cpins;

  nand_bus_cycle #(
    .WE_LOW_CYCLES  (WE_LOW_CYCLES),
    .WE_HIGH_CYCLES (WE_HIGH_CYCLES)
  ) u_bus_cycle (
    .clk     (clk),
    .rst     (rst),
    .go      (go),
    .byte_in (go_byte),
    .is_cmd  (go_cmd),
    .we_n    (bc_we_n),
    .cle     (bc_cle),
    .ale     (bc_ale),
    .io_oe   (bc_oe),
    .io_out  (bc_io),
    .active  (bc_active),
    .done    (bc_done)
  );

  // Read sequence FSM; each bus-cycle done chains the next byte in the same clock.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    idx_d     = idx_q;
    twb_cnt_d = twb_cnt_q;
    go        = 1'b0;
    go_byte   = CMD_READ_1ST;
    go_cmd    = 1'b1;
`ifdef NAND_RB_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt_q;
    timeout_err_d = timeout_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          col_d   = bus.col_addr;
          row_d   = bus.row_addr;
          state_d = S_CMD1;
`ifdef NAND_RB_TIMEOUT_EN
          timeout_err_d = 1'b0;
`endif
        end
      end
      S_CMD1: begin
        if (!bc_active) begin
          go      = 1'b1;
          go_byte = CMD_READ_1ST;
          go_cmd  = 1'b1;
        end else if (bc_done) begin
          go      = 1'b1;
          go_byte = addr_byte(col_q, row_q, 0);
          go_cmd  = 1'b0;
          idx_d   = IW'(1);
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (bc_done) begin
          go = 1'b1;
          if (idx_q == IW'(ADDR_CYCLES)) begin
            go_byte = CMD_READ_2ND;
            go_cmd  = 1'b1;
            state_d = S_CMD2;
          end else begin
            go_byte = addr_byte(col_q, row_q, int'(idx_q));
            go_cmd  = 1'b0;
            idx_d   = idx_q + IW'(1);
          end
        end
      end
      S_CMD2: begin
        if (bc_done) begin
          twb_cnt_d = '0;
          state_d   = S_TWB;
        end
      end
      S_TWB: begin
        if (twb_cnt_q == TW'(TWB_CYCLES - 1)) begin
          state_d = S_WAIT_RB;
`ifdef NAND_RB_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end else begin
          twb_cnt_d = twb_cnt_q + TW'(1);
        end
      end
      S_WAIT_RB: begin
        if (rb_sync_q) begin
          state_d = S_HANDOFF;
`ifdef NAND_RB_TIMEOUT_EN
        end else if (tmo_cnt_q == OW'(TIMEOUT_CYCLES - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + OW'(1);
`endif
        end
      end
      S_HANDOFF: begin
        if (bus.read_complete) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers and R/B# synchroniser.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      twb_cnt_q <= '0;
      rb_meta_q <= 1'b0;
      rb_sync_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      twb_cnt_q <= twb_cnt_d;
      rb_meta_q <= bus.rb_n;
      rb_sync_q <= rb_meta_q;
    end
  end

  // Latched request address, only used while the sequence runs.
  always_ff @(posedge clk) begin
    col_q <= col_d;
    row_q <= row_d;
  end

`ifdef NAND_RB_TIMEOUT_EN
  // R/B# wait watchdog and its sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign bus.timeout_err = timeout_err_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  // Pin map: CE# follows busy, RE# is left idle (owned by the data-read stage).
  always_comb begin
    cpins         = CPINS_IDLE;
    cpins[CP_WE]  = bc_we_n;
    cpins[CP_CE]  = (state_q == S_IDLE);
    cpins[CP_CLE] = bc_cle;
    cpins[CP_ALE] = bc_ale;
  end

  assign bus.CPINS      = cpins;
  assign bus.io_out     = bc_io;
  assign bus.io_oe      = bc_oe;
  assign bus.read_start = (state_q == S_HANDOFF);
  assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_nand_read_setup.sv
// tb_nand_read_setup: scoreboard bench. dut_a uses default parameters, dut_b uses
// 4 address cycles, stretched WE# timing, TWB_CYCLES=3 and TIMEOUT_CYCLES=20.
module tb_nand_read_setup;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  logic [9:0] q_a[$];
  logic [9:0] q_b[$];
  int   prev_we[2]   = '{1, 1};
  int   low_len[2]   = '{0, 0};
  int   last_fall[2] = '{-1, -1};
  int   falls[2]     = '{0, 0};
  bit   rs_seen[2]   = '{0, 0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nand_read_setup_if ifa ();
  nand_read_setup_if ifb ();

  nand_read_setup dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  nand_read_setup #(
    .ADDR_CYCLES    (4),
    .WE_LOW_CYCLES  (2),
    .WE_HIGH_CYCLES (3),
    .TWB_CYCLES     (3),
    .TIMEOUT_CYCLES (20)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  function automatic int n_addr(input int s); return (s == 0) ? 5 : 4; endfunction
  function automatic int wl(input int s);     return (s == 0) ? 1 : 2; endfunction
  function automatic int wh(input int s);     return (s == 0) ? 1 : 3; endfunction
  function automatic int twb(input int s);    return (s == 0) ? 4 : 3; endfunction

  function automatic logic [4:0] cp(input int s); return (s == 0) ? ifa.CPINS : ifb.CPINS; endfunction
  function automatic logic [7:0] io(input int s); return (s == 0) ? ifa.io_out : ifb.io_out; endfunction
  function automatic logic oe(input int s); return (s == 0) ? ifa.io_oe : ifb.io_oe; endfunction
  function automatic logic rs(input int s); return (s == 0) ? ifa.read_start : ifb.read_start; endfunction
  function automatic logic bz(input int s); return (s == 0) ? ifa.busy : ifb.busy; endfunction
  function automatic logic te(input int s); return (s == 0) ? ifa.timeout_err : ifb.timeout_err; endfunction
  function automatic int q_size(input int s); return (s == 0) ? q_a.size() : q_b.size(); endfunction

  task automatic set_start(input int s, input logic v); if (s == 0) ifa.start = v; else ifb.start = v; endtask
  task automatic set_rb(input int s, input logic v); if (s == 0) ifa.rb_n = v; else ifb.rb_n = v; endtask
  task automatic set_rc(input int s, input logic v);
    if (s == 0) ifa.read_complete = v; else ifb.read_complete = v;
  endtask
  task automatic set_addr(input int s, input logic [15:0] c, input logic [23:0] r);
    if (s == 0) begin ifa.col_addr = c; ifa.row_addr = r; end
    else begin ifb.col_addr = c; ifb.row_addr = r; end
  endtask
  task automatic push_exp(input int s, input logic [9:0] v);
    if (s == 0) q_a.push_back(v); else q_b.push_back(v);
  endtask
  task automatic tick(); @(posedge clk); #1; endtask

  // Bus monitor: every WE# rising edge is a byte the NAND latches.
  task automatic mon(input int s);
    logic [4:0] c;
    logic [9:0] got, e;
    bit         have;
    c = cp(s);
    if (rst) begin
      prev_we[s] = 1; low_len[s] = 0; last_fall[s] = -1;
      return;
    end
    if (rs(s)) rs_seen[s] = 1'b1;
    if (!bz(s)) last_fall[s] = -1;
    if (c[0] == 1'b0) begin
      if (prev_we[s] == 1) begin
        falls[s]++;
        if (last_fall[s] >= 0) begin
          n_checks++;
          if ((cyc - last_fall[s]) !== (wl(s) + wh(s)))
            $display("FAIL we_period_s%0d: got %0d clks, expected %0d", s, cyc - last_fall[s], wl(s) + wh(s));
          else n_pass++;
        end
        n_checks++;
        if (c[1] !== 1'b0 || oe(s) !== 1'b1)
          $display("FAIL we_fall_ce_oe_s%0d: got CE#=%0b io_oe=%0b, expected 0/1", s, c[1], oe(s));
        else n_pass++;
        last_fall[s] = cyc;
        low_len[s]   = 0;
      end
      low_len[s]++;
    end else if (prev_we[s] == 0) begin
      got  = {c[2], c[3], io(s)};
      have = (q_size(s) > 0);
      e    = 10'h0;
      if (have) begin
        if (s == 0) e = q_a.pop_front(); else e = q_b.pop_front();
      end
      n_checks++;
      if (!have) $display("FAIL unexpected_we_s%0d: got cle/ale/io=%03h, expected no WE# pulse", s, got);
      else if (got !== e) $display("FAIL byte_s%0d: got cle/ale/io=%03h, expected %03h", s, got, e);
      else n_pass++;
      n_checks++;
      if (low_len[s] !== wl(s)) $display("FAIL we_low_s%0d: got %0d clks, expected %0d", s, low_len[s], wl(s));
      else n_pass++;
    end
    prev_we[s] = int'(c[0]);
  endtask

  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) mon(s);
  end

  // Queue the expected byte sequence and present a one-clock start (or hold it).
  task automatic issue(input int s, input logic [15:0] col, input logic [23:0] row, input bit hold);
    logic [39:0] ab;
    ab = {row, col};
    push_exp(s, {2'b10, 8'h00});
    for (int i = 0; i < n_addr(s); i++) push_exp(s, {2'b01, ab[8*i +: 8]});
    push_exp(s, {2'b10, 8'h30});
    set_addr(s, col, row);
    set_start(s, 1'b1);
    tick();
    if (!hold) set_start(s, 1'b0);
    set_addr(s, 16'hFFFF, 24'hFFFFFF);
  endtask

  task automatic wait_bytes(input int s, input int bound);
    int i;
    i = 0;
    while (q_size(s) != 0 && i < bound) begin tick(); i++; end
    n_checks++;
    if (q_size(s) != 0) $display("FAIL bytes_sent_s%0d: %0d bytes outstanding, expected 0", s, q_size(s));
    else n_pass++;
  endtask

  task automatic wait_rs(input int s, input int bound, output int n);
    n = 1;
    while (!rs(s) && n < bound) begin tick(); n++; end
  endtask

  task automatic finish_read(input int s);
    n_checks++;
    if (rs(s) !== 1'b1 || cp(s) !== 5'b10001 || oe(s) !== 1'b0)
      $display("FAIL handoff_s%0d: got read_start=%0b CPINS=%05b io_oe=%0b, expected 1/10001/0", s, rs(s), cp(s), oe(s));
    else n_pass++;
    set_rc(s, 1'b1);
    tick();
    set_rc(s, 1'b0);
    n_checks++;
    if (rs(s) !== 1'b0 || cp(s) !== 5'b10011 || bz(s) !== 1'b0)
      $display("FAIL complete_s%0d: got read_start=%0b CPINS=%05b busy=%0b, expected 0/10011/0", s, rs(s), cp(s), bz(s));
    else n_pass++;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if (cp(s) !== 5'b10011 || io(s) !== 8'h00 || oe(s) !== 1'b0 || rs(s) !== 1'b0 || bz(s) !== 1'b0 || te(s) !== 1'b0)
        $display("FAIL reset_s%0d: got CPINS=%05b io=%02h oe=%0b rs=%0b busy=%0b te=%0b, expected 10011/00/0/0/0/0",
                 s, cp(s), io(s), oe(s), rs(s), bz(s), te(s));
      else n_pass++;
    end
  endtask

  task automatic test_basic();
    int f0, n;
    f0 = falls[0];
    set_rb(0, 1'b0);
    issue(0, 16'h0123, 24'h045678, 1'b0);
    n_checks++;
    if (bz(0) !== 1'b1 || cp(0) !== 5'b10001)
      $display("FAIL accept: got busy=%0b CPINS=%05b, expected 1/10001", bz(0), cp(0));
    else n_pass++;
    wait_bytes(0, 100);
    repeat (14) tick();
    n_checks++;
    if (rs(0) !== 1'b0 || bz(0) !== 1'b1 || oe(0) !== 1'b0)
      $display("FAIL rb_busy_wait: got read_start=%0b busy=%0b io_oe=%0b, expected 0/1/0", rs(0), bz(0), oe(0));
    else n_pass++;
    set_rb(0, 1'b1);
    tick(); tick();
    n_checks++;
    if (rs(0) !== 1'b0) $display("FAIL rb_sync_early: got read_start=%0b, expected 0", rs(0));
    else n_pass++;
    tick();
    n_checks++;
    if (rs(0) !== 1'b1) $display("FAIL rb_sync_latency: got read_start=%0b, expected 1", rs(0));
    else n_pass++;
    repeat (3) tick();
    n_checks++;
    if (falls[0] - f0 !== 7) $display("FAIL we_count_5: got %0d pulses, expected 7", falls[0] - f0);
    else n_pass++;
    finish_read(0);
    wait_rs(0, 1, n);
  endtask

  task automatic test_addr4();
    int f0, n;
    f0 = falls[1];
    set_rb(1, 1'b0);
    issue(1, 16'hBEEF, 24'h9A5C3D, 1'b0);
    wait_bytes(1, 200);
    repeat (8) tick();
    set_rb(1, 1'b1);
    wait_rs(1, 20, n);
    n_checks++;
    if (rs(1) !== 1'b1) $display("FAIL addr4_read_start: got %0b after %0d clks, expected 1", rs(1), n);
    else n_pass++;
    n_checks++;
    if (falls[1] - f0 !== 6) $display("FAIL we_count_4: got %0d pulses, expected 6", falls[1] - f0);
    else n_pass++;
    finish_read(1);
  endtask

  task automatic test_start_held();
    int n;
    set_rb(0, 1'b0);
    issue(0, 16'hA5C3, 24'h00FF10, 1'b1);
    set_rc(0, 1'b1);
    tick();
    set_rc(0, 1'b0);
    n_checks++;
    if (bz(0) !== 1'b1) $display("FAIL rc_ignored: got busy=%0b, expected 1", bz(0));
    else n_pass++;
    wait_bytes(0, 100);
    repeat (6) tick();
    set_rb(0, 1'b1);
    wait_rs(0, 20, n);
    set_start(0, 1'b0);
    tick();
    set_start(0, 1'b1);
    tick();
    set_start(0, 1'b0);
    finish_read(0);
    n = 0;
    repeat (6) begin tick(); if (bz(0) !== 1'b0 || q_size(0) != 0) n++; end
    n_checks++;
    if (n != 0) $display("FAIL start_ignored: got %0d busy clocks after completion, expected 0", n);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int f0, i, n;
    f0 = falls[0];
    set_rb(0, 1'b0);
    issue(0, 16'h1357, 24'h2468AC, 1'b0);
    i = 0;
    while (falls[0] - f0 < 4 && i < 50) begin tick(); i++; end
    rst = 1'b1;
    tick();
    n_checks++;
    if (cp(0) !== 5'b10011 || oe(0) !== 1'b0 || bz(0) !== 1'b0 || io(0) !== 8'h00)
      $display("FAIL mid_reset: got CPINS=%05b io_oe=%0b busy=%0b io=%02h, expected 10011/0/0/00", cp(0), oe(0), bz(0), io(0));
    else n_pass++;
    rst = 1'b0;
    q_a.delete();
    tick();
    issue(0, 16'h0F1E, 24'h2D3C4B, 1'b0);
    wait_bytes(0, 100);
    repeat (5) tick();
    set_rb(0, 1'b1);
    wait_rs(0, 20, n);
    finish_read(0);
  endtask

  task automatic test_back_to_back();
    int n;
    set_rb(1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      issue(1, 16'h4400 + 16'(k), 24'h778899 - 24'(k), 1'b0);
      wait_bytes(1, 200);
      wait_rs(1, 40, n);
      n_checks++;
      if (n !== wh(1) + twb(1) + 1)
        $display("FAIL twb_latency_%0d: got read_start %0d clks after last WE# rise, expected %0d", k, n, wh(1) + twb(1) + 1);
      else n_pass++;
      finish_read(1);
    end
  endtask

  task automatic test_timeout();
    int n;
    rs_seen[1] = 1'b0;
    set_rb(1, 1'b0);
    issue(1, 16'h0001, 24'h000002, 1'b0);
    wait_bytes(1, 200);
`ifdef NAND_RB_TIMEOUT_EN
    n = 1;
    while (bz(1) && n < 200) begin tick(); n++; end
    n_checks++;
    if (n !== wh(1) + twb(1) + 20)
      $display("FAIL timeout_latency: got idle %0d clks after last WE# rise, expected %0d", n, wh(1) + twb(1) + 20);
    else n_pass++;
    n_checks++;
    if (te(1) !== 1'b1 || cp(1) !== 5'b10011 || rs_seen[1] !== 1'b0)
      $display("FAIL timeout_state: got timeout_err=%0b CPINS=%05b read_start_seen=%0b, expected 1/10011/0", te(1), cp(1), rs_seen[1]);
    else n_pass++;
    tick();
    issue(1, 16'h0003, 24'h000004, 1'b0);
    n_checks++;
    if (te(1) !== 1'b0) $display("FAIL timeout_clear: got timeout_err=%0b, expected 0", te(1));
    else n_pass++;
    wait_bytes(1, 200);
`else
    repeat (60) tick();
    n_checks++;
    if (te(1) !== 1'b0 || bz(1) !== 1'b1 || rs(1) !== 1'b0)
      $display("FAIL no_timeout: got timeout_err=%0b busy=%0b read_start=%0b, expected 0/1/0", te(1), bz(1), rs(1));
    else n_pass++;
`endif
    set_rb(1, 1'b1);
    wait_rs(1, 20, n);
    finish_read(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      set_start(s, 1'b0); set_rb(s, 1'b1); set_rc(s, 1'b0); set_addr(s, 16'h0, 24'h0);
    end
    repeat (3) tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_addr4();
    test_start_held();
    test_reset_mid();
    test_back_to_back();
    test_timeout();
    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
